// File: rtl/lsu_pkg.sv
// Shared load/store unit widths and the store buffer entry layout.
package lsu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] loc;
    } sb_entry_t;

endpackage

// File: rtl/sb_search_prio.sv
// Youngest-match selector; bit 0 of the rotated vectors is the youngest entry.
module sb_search_prio
    import lsu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]             match_rot,
    input  logic [DEPTH-1:0][DATA_W-1:0] data_rot,
    output logic                         hit,
    output logic [DATA_W-1:0]            hit_data
);

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_rot[i]) begin
                hit      = 1'b1;
                hit_data = data_rot[i];
            end
        end
    end

endmodule

// File: rtl/store_buffer_fifo.sv
// Circular speculative store buffer: in-order enqueue, committed drain from head,
// youngest-match load forwarding.
module store_buffer_fifo
    import lsu_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 1
) (
    input  logic              clk,
    input  logic              flush,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] location,
    input  logic              input_valid,
    input  logic [ADDR_W-1:0] search_location,
    input  logic [1:0]        stores_to_commit,
    output logic [DATA_W-1:0] commit_data,
    output logic [ADDR_W-1:0] commit_location,
    output logic              commit_valid,
    output logic [DATA_W-1:0] search_data,
    output logic              search_valid,
    output logic              store_stall
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] ccnt;

    logic             full;
    logic             enq_accept;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] ccnt_next;

    logic [DEPTH-1:0]             match_rot;
    logic [DEPTH-1:0][DATA_W-1:0] data_rot;
    logic [PTR_W-1:0]             idx;

    assign full            = (count == CNT_W'(DEPTH));
    assign commit_valid    = (ccnt != '0) && entries[head].valid;
    assign commit_data     = entries[head].data;
    assign commit_location = entries[head].loc;

    // A full ring still accepts when the head slot is freed this same edge.
    assign enq_accept = input_valid && (!full || commit_valid);

    assign count_next = count + CNT_W'(enq_accept) - CNT_W'(commit_valid);
    assign ccnt_next  = ccnt + CNT_W'(stores_to_commit) - CNT_W'(commit_valid);

    assign store_stall = (CNT_W'(DEPTH) - count) <= CNT_W'(STALL_MARGIN);

    // Present entries youngest-first: slot i of the rotated view is tail-1-i.
    always_comb begin
        match_rot = '0;
        data_rot  = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx          = tail - PTR_W'(i + 1);
            match_rot[i] = entries[idx].valid && (entries[idx].loc == search_location);
            data_rot[i]  = entries[idx].data;
        end
    end

    sb_search_prio #(
        .DEPTH (DEPTH)
    ) u_search (
        .match_rot (match_rot),
        .data_rot  (data_rot),
        .hit       (search_valid),
        .hit_data  (search_data)
    );

    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ccnt  <= '0;
        end else begin
            if (commit_valid) begin
                entries[head].valid <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            // Placed after the drain clear so a full-ring refill of the head slot wins.
            if (enq_accept) begin
                entries[tail] <= '{valid: 1'b1, data: data, loc: location};
                tail          <= tail + PTR_W'(1);
            end
            count <= count_next;
            ccnt  <= ccnt_next;
        end
    end

endmodule

// File: tb/tb_store_buffer_fifo.sv
// Directed bench for store_buffer_fifo: forwarding, commit/drain, full/stall, wrap, flush.
module tb_store_buffer_fifo;

    logic        clk = 1'b0;
    logic        flush;
    logic [15:0] data;
    logic [15:0] location;
    logic        input_valid;
    logic [15:0] search_location;
    logic [1:0]  stores_to_commit;
    logic [15:0] commit_data;
    logic [15:0] commit_location;
    logic        commit_valid;
    logic [15:0] search_data;
    logic        search_valid;
    logic        store_stall;

    int checks   = 0;
    int failures = 0;
    int pend     = 0;

    always #5 clk = ~clk;

    store_buffer_fifo #(
        .DEPTH        (8),
        .STALL_MARGIN (1)
    ) dut (
        .clk              (clk),
        .flush            (flush),
        .data             (data),
        .location         (location),
        .input_valid      (input_valid),
        .search_location  (search_location),
        .stores_to_commit (stores_to_commit),
        .commit_data      (commit_data),
        .commit_location  (commit_location),
        .commit_valid     (commit_valid),
        .search_data      (search_data),
        .search_valid     (search_valid),
        .store_stall      (store_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        input_valid      = 1'b0;
        stores_to_commit = 2'd0;
        flush            = 1'b0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic enq(input logic [15:0] d, input logic [15:0] l, input bit acc);
        input_valid = 1'b1;
        data        = d;
        location    = l;
        if (acc) pend++;
    endtask

    // The ROB may only retire stores that are buffered and not yet committed.
    task automatic commit(input int n);
        checks++;
        assert (n <= pend) else begin
            failures++;
            $error("FAIL commit_protocol observed=%0d expected<=%0d", n, pend);
        end
        pend             = pend - n;
        stores_to_commit = 2'(n);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        pend  = 0;
    endtask

    task automatic srch(input string tag, input logic [15:0] l,
                        input logic ev, input logic [15:0] ed);
        search_location = l;
        #1;
        chk({tag, ".valid"}, 32'(search_valid), 32'(ev));
        chk({tag, ".data"}, 32'(search_data), 32'(ed));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        flush            = 1'b1;
        data             = '0;
        location         = '0;
        input_valid      = 1'b0;
        search_location  = '0;
        stores_to_commit = 2'd0;
        tick();
        settle();
        chk("rst.commit_valid", 32'(commit_valid), 32'd0);
        chk("rst.commit_data", 32'(commit_data), 32'd0);
        chk("rst.commit_location", 32'(commit_location), 32'd0);
        chk("rst.store_stall", 32'(store_stall), 32'd0);
        srch("rst.search", 16'h0000, 1'b0, 16'h0000);

        // Forwarding picks the younger of two stores to the same address
        enq(16'hAAAA, 16'h0010, 1'b1); tick();
        enq(16'hBBBB, 16'h0010, 1'b1); tick();
        settle();
        srch("fwd.hit", 16'h0010, 1'b1, 16'hBBBB);
        srch("fwd.miss", 16'h0020, 1'b0, 16'h0000);
        chk("fwd.commit_valid", 32'(commit_valid), 32'd0);

        // Commit two of three, they drain in order on the next two cycles
        do_flush(); tick();
        enq(16'h1111, 16'h0100, 1'b1); tick();
        enq(16'h2222, 16'h0101, 1'b1); tick();
        enq(16'h3333, 16'h0102, 1'b1); tick();
        commit(2);
        settle();
        chk("drain.same_cycle", 32'(commit_valid), 32'd0);
        tick(); settle();
        chk("drain.c1.valid", 32'(commit_valid), 32'd1);
        chk("drain.c1.data", 32'(commit_data), 32'h1111);
        chk("drain.c1.loc", 32'(commit_location), 32'h0100);
        tick(); settle();
        chk("drain.c2.valid", 32'(commit_valid), 32'd1);
        chk("drain.c2.data", 32'(commit_data), 32'h2222);
        chk("drain.c2.loc", 32'(commit_location), 32'h0101);
        tick(); settle();
        chk("drain.c3.valid", 32'(commit_valid), 32'd0);
        srch("drain.s3", 16'h0102, 1'b1, 16'h3333);
        srch("drain.s1_gone", 16'h0100, 1'b0, 16'h0000);

        // Fill to stall, then full, then drop an enqueue with no drain
        do_flush(); tick();
        for (int i = 0; i < 6; i++) begin
            enq(16'(16'h1000 + i), 16'(16'h0200 + i), 1'b1); tick();
        end
        settle();
        chk("full.stall_at6", 32'(store_stall), 32'd0);
        enq(16'h1006, 16'h0206, 1'b1); tick();
        settle();
        chk("full.stall_at7", 32'(store_stall), 32'd1);
        enq(16'h1007, 16'h0207, 1'b1); tick();
        settle();
        chk("full.stall_at8", 32'(store_stall), 32'd1);
        srch("full.s8", 16'h0207, 1'b1, 16'h1007);
        enq(16'h1008, 16'h0208, 1'b0); tick();
        settle();
        srch("full.dropped", 16'h0208, 1'b0, 16'h0000);
        srch("full.head_kept", 16'h0200, 1'b1, 16'h1000);
        commit(1); tick();
        settle();
        chk("full.drain.valid", 32'(commit_valid), 32'd1);
        chk("full.drain.data", 32'(commit_data), 32'h1000);
        chk("full.drain.loc", 32'(commit_location), 32'h0200);
        enq(16'h1009, 16'h0209, 1'b1); tick();
        settle();
        chk("full.refill.cv", 32'(commit_valid), 32'd0);
        chk("full.refill.stall", 32'(store_stall), 32'd1);
        chk("full.refill.head_loc", 32'(commit_location), 32'h0201);
        srch("full.refill.new", 16'h0209, 1'b1, 16'h1009);
        srch("full.refill.old", 16'h0200, 1'b0, 16'h0000);

        // Interleaved enqueue/commit across two pointer wraps
        do_flush(); tick();
        for (int i = 0; i < 20; i++) begin
            if (i >= 1) commit(1);
            enq(16'(16'h5000 + i), 16'(16'h0300 + (i % 2)), 1'b1);
            settle();
            if (i >= 2) begin
                chk($sformatf("wrap.c%0d.valid", i), 32'(commit_valid), 32'd1);
                chk($sformatf("wrap.c%0d.data", i), 32'(commit_data), 32'(16'h5000 + i - 2));
            end else begin
                chk($sformatf("wrap.c%0d.valid", i), 32'(commit_valid), 32'd0);
            end
            tick();
        end
        settle();
        chk("wrap.tail.valid", 32'(commit_valid), 32'd1);
        chk("wrap.tail.data", 32'(commit_data), 32'h5012);
        tick();
        enq(16'h6004, 16'h0400, 1'b1); tick();
        enq(16'h6005, 16'h0401, 1'b1); tick();
        enq(16'h6006, 16'h0400, 1'b1); tick();
        enq(16'h6007, 16'h0402, 1'b1); tick();
        enq(16'h6000, 16'h0400, 1'b1); tick();
        enq(16'h6001, 16'h0403, 1'b1); tick();
        settle();
        srch("wrap.dup_youngest", 16'h0400, 1'b1, 16'h6000);
        srch("wrap.s401", 16'h0401, 1'b1, 16'h6005);
        srch("wrap.s301", 16'h0301, 1'b1, 16'h5013);
        srch("wrap.s300", 16'h0300, 1'b0, 16'h0000);
        tick(); settle();
        srch("wrap.s402", 16'h0402, 1'b1, 16'h6007);
        chk("wrap.cv_idle", 32'(commit_valid), 32'd0);

        // Flush with committed stores pending and a competing enqueue
        do_flush(); tick();
        for (int i = 0; i < 5; i++) begin
            enq(16'(16'h7700 + i), 16'(16'h0700 + i), 1'b1); tick();
        end
        commit(2); tick();
        settle();
        chk("flush.pre.valid", 32'(commit_valid), 32'd1);
        chk("flush.pre.data", 32'(commit_data), 32'h7700);
        enq(16'h9900, 16'h0900, 1'b0);
        do_flush(); tick();
        settle();
        chk("flush.cv", 32'(commit_valid), 32'd0);
        chk("flush.cdata", 32'(commit_data), 32'd0);
        chk("flush.cloc", 32'(commit_location), 32'd0);
        chk("flush.stall", 32'(store_stall), 32'd0);
        srch("flush.s700", 16'h0700, 1'b0, 16'h0000);
        srch("flush.s900", 16'h0900, 1'b0, 16'h0000);
        enq(16'h8800, 16'h0800, 1'b1); tick();
        settle();
        chk("flush.idx0.loc", 32'(commit_location), 32'h0800);
        chk("flush.idx0.data", 32'(commit_data), 32'h8800);
        chk("flush.idx0.cv", 32'(commit_valid), 32'd0);

        // A store being enqueued is invisible to a search in the same cycle
        enq(16'h3030, 16'h0030, 1'b1);
        settle();
        srch("vis.same", 16'h0030, 1'b0, 16'h0000);
        tick(); settle();
        srch("vis.next", 16'h0030, 1'b1, 16'h3030);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
